// File: rtl/nk_game_pkg.sv
// Shared types for the N x N, K-in-a-row game manager: game_state codes,
// win-scan FSM states and the scan direction table.
package nk_game_pkg;

  typedef enum logic [2:0] {
    ST_P1_TURN = 3'd0,
    ST_P2_TURN = 3'd1,
    ST_DRAW    = 3'd2,
    ST_P1_WIN  = 3'd3,
    ST_P2_WIN  = 3'd4
  } game_state_e;

  typedef enum logic [2:0] {
    IDLE,
    SCAN_POS,
    SCAN_NEG,
    NEXT_DIR,
    RESOLVE
  } scan_state_e;

  typedef struct packed {
    logic signed [1:0] dx;
    logic signed [1:0] dy;
  } dir_t;

  // Scan order: horizontal, vertical, diagonal, anti-diagonal.
  function automatic dir_t dir_lookup(input logic [1:0] idx);
    dir_t d;
    case (idx)
      2'd0:    begin d.dx = 2'sd1; d.dy = 2'sd0;  end
      2'd1:    begin d.dx = 2'sd0; d.dy = 2'sd1;  end
      2'd2:    begin d.dx = 2'sd1; d.dy = 2'sd1;  end
      default: begin d.dx = 2'sd1; d.dy = -2'sd1; end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/nk_win_scanner.sv
// Sequential K-in-a-row detector: walks out from the origin cell one cell
// per clock along each of the four directions, both senses.
module nk_win_scanner
  import nk_game_pkg::*;
#(
  parameter int N = 3,
  parameter int K = 3,
  localparam int CW = $clog2(N),
  localparam int CELLS = N * N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CW-1:0]    origin_x,
  input  logic [CW-1:0]    origin_y,
  input  logic [CELLS-1:0] grid,
  output logic             done,
  output logic             win
);

  localparam int RW = $clog2(K + 1);
  localparam int IW = $clog2(CELLS);

  scan_state_e         state_q, state_d;
  logic [1:0]          dir_q, dir_d;
  logic [RW-1:0]       run_q, run_d;
  logic signed [CW:0]  cx_q, cx_d, cy_q, cy_d;
  logic [CW-1:0]       ox_q, ox_d, oy_q, oy_d;
  logic                win_q, win_d;

  dir_t                dir;
  logic signed [CW:0]  sdx, sdy, nx, ny;
  logic                inb, hit;
  logic [IW-1:0]       idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      dir_q   <= '0;
      run_q   <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      win_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      run_q   <= run_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      win_q   <= win_d;
    end
  end

  always_comb begin
    dir = dir_lookup(dir_q);
    sdx = {{(CW - 1){dir.dx[1]}}, dir.dx};
    sdy = {{(CW - 1){dir.dy[1]}}, dir.dy};
    if (state_q == SCAN_NEG) begin
      sdx = -sdx;
      sdy = -sdy;
    end
    nx = cx_q + sdx;
    ny = cy_q + sdy;
    // A step past N-1 may wrap into the sign bit when N is a power of two;
    // that still reads as out of bounds.
    inb = !nx[CW] && !ny[CW] &&
          (nx[CW-1:0] <= CW'(N - 1)) && (ny[CW-1:0] <= CW'(N - 1));
    idx = IW'(ny[CW-1:0]) * IW'(N) + IW'(nx[CW-1:0]);
    hit = inb && grid[idx];

    state_d = state_q;
    dir_d   = dir_q;
    run_d   = run_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    win_d   = win_q;
    done    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN_POS;
          dir_d   = '0;
          run_d   = RW'(1);
          ox_d    = origin_x;
          oy_d    = origin_y;
          cx_d    = {1'b0, origin_x};
          cy_d    = {1'b0, origin_y};
          win_d   = 1'b0;
        end
      end
      SCAN_POS, SCAN_NEG: begin
        if (hit && (run_q < RW'(K))) begin
          cx_d  = nx;
          cy_d  = ny;
          run_d = run_q + RW'(1);
          if (run_q + RW'(1) == RW'(K)) begin
            state_d = RESOLVE;
            win_d   = 1'b1;
          end
        end else if (state_q == SCAN_POS) begin
          state_d = SCAN_NEG;
          cx_d    = {1'b0, ox_q};
          cy_d    = {1'b0, oy_q};
        end else begin
          state_d = NEXT_DIR;
        end
      end
      NEXT_DIR: begin
        if (dir_q == 2'd3) begin
          state_d = RESOLVE;
        end else begin
          state_d = SCAN_POS;
          dir_d   = dir_q + 2'd1;
          run_d   = RW'(1);
          cx_d    = {1'b0, ox_q};
          cy_d    = {1'b0, oy_q};
        end
      end
      RESOLVE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign win = win_q;

endmodule

// File: rtl/nk_game_manager.sv
// N x N, K-in-a-row game manager: cursor, occupancy grids, turn/result
// tracking and games-played counter; win detection delegated to the scanner.
module nk_game_manager
  import nk_game_pkg::*;
#(
  parameter int N         = 3,
  parameter int K         = 3,
  parameter int WRAP      = 0,
  parameter int ALT_START = 0,
  parameter int CNT_W     = 4,
  localparam int CW = $clog2(N),
  localparam int CELLS = N * N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_place,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_left,
  input  logic             btn_right,
  output logic [CW-1:0]    cursor_x,
  output logic [CW-1:0]    cursor_y,
  output logic [CELLS-1:0] p1_grid,
  output logic [CELLS-1:0] p2_grid,
  output logic [2:0]       game_state,
  output logic [CNT_W-1:0] games_played,
  output logic             busy
);

  localparam int FW = $clog2(CELLS + 1);
  localparam int IW = $clog2(CELLS);
  localparam logic [CW-1:0] MAXC = CW'(N - 1);
  localparam logic [CW-1:0] MIDC = CW'(N / 2);

  game_state_e      gs_q;
  logic             starter_q;
  logic [FW-1:0]    filled_q;
  logic             start_q;

  logic [IW-1:0]    cidx;
  logic             occupied, playing, p2_moves;
  logic [CELLS-1:0] mover_grid;
  logic [CNT_W-1:0] games_inc;
  logic             scan_done, scan_win;

  always_comb begin
    cidx       = IW'(cursor_y) * IW'(N) + IW'(cursor_x);
    occupied   = p1_grid[cidx] | p2_grid[cidx];
    playing    = (gs_q == ST_P1_TURN) || (gs_q == ST_P2_TURN);
    p2_moves   = (gs_q == ST_P2_TURN);
    mover_grid = p2_moves ? p2_grid : p1_grid;
    games_inc  = (games_played == '1) ? games_played : games_played + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1_grid      <= '0;
      p2_grid      <= '0;
      cursor_x     <= '0;
      cursor_y     <= '0;
      gs_q         <= ST_P1_TURN;
      games_played <= '0;
      busy         <= 1'b0;
      starter_q    <= 1'b0;
      filled_q     <= '0;
      start_q      <= 1'b0;
    end else begin
      start_q <= 1'b0;
      if (busy) begin
        // game_state still names the mover until the scan result lands.
        if (scan_done) begin
          busy <= 1'b0;
          if (scan_win) begin
            gs_q         <= p2_moves ? ST_P2_WIN : ST_P1_WIN;
            games_played <= games_inc;
          end else if (filled_q == FW'(CELLS)) begin
            gs_q         <= ST_DRAW;
            games_played <= games_inc;
          end else begin
            gs_q <= p2_moves ? ST_P1_TURN : ST_P2_TURN;
          end
        end
      end else if (playing) begin
        if (btn_place) begin
          if (!occupied) begin
            if (p2_moves) p2_grid[cidx] <= 1'b1;
            else          p1_grid[cidx] <= 1'b1;
            filled_q <= filled_q + FW'(1);
            busy     <= 1'b1;
            start_q  <= 1'b1;
          end
        end else if (btn_up) begin
          if (cursor_y != '0)  cursor_y <= cursor_y - CW'(1);
          else if (WRAP != 0)  cursor_y <= MAXC;
        end else if (btn_down) begin
          if (cursor_y != MAXC) cursor_y <= cursor_y + CW'(1);
          else if (WRAP != 0)   cursor_y <= '0;
        end else if (btn_left) begin
          if (cursor_x != '0)  cursor_x <= cursor_x - CW'(1);
          else if (WRAP != 0)  cursor_x <= MAXC;
        end else if (btn_right) begin
          if (cursor_x != MAXC) cursor_x <= cursor_x + CW'(1);
          else if (WRAP != 0)   cursor_x <= '0;
        end
      end else if (btn_place) begin
        p1_grid  <= '0;
        p2_grid  <= '0;
        filled_q <= '0;
        cursor_x <= MIDC;
        cursor_y <= MIDC;
        if (ALT_START != 0) begin
          starter_q <= ~starter_q;
          gs_q      <= starter_q ? ST_P1_TURN : ST_P2_TURN;
        end else begin
          gs_q <= ST_P1_TURN;
        end
      end
    end
  end

  assign game_state = gs_q;

  nk_win_scanner #(
    .N(N),
    .K(K)
  ) u_scanner (
    .clk      (clk),
    .rst      (rst),
    .start    (start_q),
    .origin_x (cursor_x),
    .origin_y (cursor_y),
    .grid     (mover_grid),
    .done     (scan_done),
    .win      (scan_win)
  );

endmodule

// File: tb/tb_nk_game_manager.sv
// Directed bench for nk_game_manager: four instances cover saturating and
// wrapping cursors, 5x5 K=4 play and alternating-start with mid-scan reset.
module tb_nk_game_manager;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] btn [4];   // {right, left, down, up, place}
  int mx [4];
  int my [4];
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  logic [1:0] cx_a, cy_a, cx_b, cy_b, cx_d, cy_d;
  logic [2:0] cx_c, cy_c;
  logic [8:0] p1_a, p2_a, p1_b, p2_b, p1_d, p2_d;
  logic [24:0] p1_c, p2_c;
  logic [2:0] gs_a, gs_b, gs_c, gs_d;
  logic [3:0] gp_a, gp_b, gp_c, gp_d;
  logic busy_a, busy_b, busy_c, busy_d;

  nk_game_manager #(.N(3), .K(3), .WRAP(0), .ALT_START(0), .CNT_W(4)) u_a (
    .clk(clk), .rst(rst), .btn_place(btn[0][0]), .btn_up(btn[0][1]),
    .btn_down(btn[0][2]), .btn_left(btn[0][3]), .btn_right(btn[0][4]),
    .cursor_x(cx_a), .cursor_y(cy_a), .p1_grid(p1_a), .p2_grid(p2_a),
    .game_state(gs_a), .games_played(gp_a), .busy(busy_a));

  nk_game_manager #(.N(3), .K(3), .WRAP(1), .ALT_START(0), .CNT_W(4)) u_b (
    .clk(clk), .rst(rst), .btn_place(btn[1][0]), .btn_up(btn[1][1]),
    .btn_down(btn[1][2]), .btn_left(btn[1][3]), .btn_right(btn[1][4]),
    .cursor_x(cx_b), .cursor_y(cy_b), .p1_grid(p1_b), .p2_grid(p2_b),
    .game_state(gs_b), .games_played(gp_b), .busy(busy_b));

  nk_game_manager #(.N(5), .K(4), .WRAP(0), .ALT_START(0), .CNT_W(4)) u_c (
    .clk(clk), .rst(rst), .btn_place(btn[2][0]), .btn_up(btn[2][1]),
    .btn_down(btn[2][2]), .btn_left(btn[2][3]), .btn_right(btn[2][4]),
    .cursor_x(cx_c), .cursor_y(cy_c), .p1_grid(p1_c), .p2_grid(p2_c),
    .game_state(gs_c), .games_played(gp_c), .busy(busy_c));

  nk_game_manager #(.N(3), .K(3), .WRAP(0), .ALT_START(1), .CNT_W(4)) u_d (
    .clk(clk), .rst(rst), .btn_place(btn[3][0]), .btn_up(btn[3][1]),
    .btn_down(btn[3][2]), .btn_left(btn[3][3]), .btn_right(btn[3][4]),
    .cursor_x(cx_d), .cursor_y(cy_d), .p1_grid(p1_d), .p2_grid(p2_d),
    .game_state(gs_d), .games_played(gp_d), .busy(busy_d));

  // Field codes: 0 cursor_x, 1 cursor_y, 2 p1_grid, 3 p2_grid,
  // 4 game_state, 5 games_played, 6 busy.
  function automatic logic [31:0] obs(input int d, input int f);
    logic [31:0] v [7];
    for (int i = 0; i < 7; i++) v[i] = '0;
    case (d)
      0: begin v[0] = 32'(cx_a); v[1] = 32'(cy_a); v[2] = 32'(p1_a); v[3] = 32'(p2_a);
               v[4] = 32'(gs_a); v[5] = 32'(gp_a); v[6] = 32'(busy_a); end
      1: begin v[0] = 32'(cx_b); v[1] = 32'(cy_b); v[2] = 32'(p1_b); v[3] = 32'(p2_b);
               v[4] = 32'(gs_b); v[5] = 32'(gp_b); v[6] = 32'(busy_b); end
      2: begin v[0] = 32'(cx_c); v[1] = 32'(cy_c); v[2] = 32'(p1_c); v[3] = 32'(p2_c);
               v[4] = 32'(gs_c); v[5] = 32'(gp_c); v[6] = 32'(busy_c); end
      default: begin v[0] = 32'(cx_d); v[1] = 32'(cy_d); v[2] = 32'(p1_d); v[3] = 32'(p2_d);
               v[4] = 32'(gs_d); v[5] = 32'(gp_d); v[6] = 32'(busy_d); end
    endcase
    return v[f];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic press(input int d, input int b);
    @(negedge clk);
    btn[d] = 5'd1 << b;
    @(negedge clk);
    btn[d] = '0;
  endtask

  task automatic move_to(input int d, input int x, input int y);
    while (my[d] > y) begin press(d, 1); my[d]--; end
    while (my[d] < y) begin press(d, 2); my[d]++; end
    while (mx[d] > x) begin press(d, 3); mx[d]--; end
    while (mx[d] < x) begin press(d, 4); mx[d]++; end
    check($sformatf("d%0d_cur_x_%0d_%0d", d, x, y), obs(d, 0), 32'(x));
    check($sformatf("d%0d_cur_y_%0d_%0d", d, x, y), obs(d, 1), 32'(y));
  endtask

  task automatic play(input int d, input int x, input int y, input int exp_gs);
    int cyc;
    int bound;
    cyc = 0;
    bound = (d == 2) ? 30 : 27;
    move_to(d, x, y);
    press(d, 0);
    check($sformatf("d%0d_busy_hi_%0d_%0d", d, x, y), obs(d, 6), 1);
    while (obs(d, 6) != 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check($sformatf("d%0d_busy_lo_%0d_%0d", d, x, y), obs(d, 6), 0);
    check($sformatf("d%0d_busy_len_%0d_%0d", d, x, y), (cyc <= bound) ? 1 : 0, 1);
    check($sformatf("d%0d_state_%0d_%0d", d, x, y), obs(d, 4), 32'(exp_gs));
  endtask

  task automatic new_game(input int d, input int exp_gs);
    press(d, 0);
    mx[d] = 1;
    my[d] = 1;
    check($sformatf("d%0d_ng_p1", d), obs(d, 2), 0);
    check($sformatf("d%0d_ng_p2", d), obs(d, 3), 0);
    check($sformatf("d%0d_ng_cx", d), obs(d, 0), 1);
    check($sformatf("d%0d_ng_cy", d), obs(d, 1), 1);
    check($sformatf("d%0d_ng_state", d), obs(d, 4), 32'(exp_gs));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      btn[i] = '0;
      mx[i] = 0;
      my[i] = 0;
    end
    #12;
    for (int d = 0; d < 4; d++)
      for (int f = 0; f < 7; f++)
        check($sformatf("rst_d%0d_f%0d", d, f), obs(d, f), 0);
    rst = 1'b0;

    // Edge behaviour of the cursor: saturate vs wrap.
    for (int i = 0; i < 3; i++) press(0, 4);
    mx[0] = 2;
    check("sat_right_x", obs(0, 0), 2);
    for (int i = 0; i < 3; i++) press(1, 4);
    check("wrap_right_x", obs(1, 0), 0);
    @(negedge clk);
    btn[1] = 5'b01010;  // up and left together: up wins
    @(negedge clk);
    btn[1] = '0;
    check("prio_up_y", obs(1, 1), 2);
    check("prio_up_x", obs(1, 0), 0);

    // Game 1 on u_a: occupied-cell place ignored, then P1 diagonal win.
    play(0, 0, 0, 1);
    press(0, 0);
    check("occ_p2_grid", obs(0, 3), 0);
    check("occ_state", obs(0, 4), 1);
    check("occ_busy", obs(0, 6), 0);
    play(0, 1, 0, 0);
    play(0, 1, 1, 1);
    play(0, 2, 0, 0);
    play(0, 2, 2, 3);
    check("g1_games", obs(0, 5), 1);
    check("g1_p1", obs(0, 2), 32'h111);
    check("g1_p2", obs(0, 3), 32'h006);
    press(0, 3);
    check("g1_over_move", obs(0, 0), 2);
    new_game(0, 0);
    check("g1_ng_games", obs(0, 5), 1);

    // Game 2: drawn board.
    play(0, 0, 0, 1); play(0, 1, 0, 0); play(0, 2, 0, 1);
    play(0, 1, 1, 0); play(0, 1, 2, 1); play(0, 2, 1, 0);
    play(0, 0, 1, 1); play(0, 0, 2, 0); play(0, 2, 2, 2);
    check("g2_games", obs(0, 5), 2);
    check("g2_p1", obs(0, 2), 397);
    check("g2_p2", obs(0, 3), 114);
    new_game(0, 0);

    // Game 3: ninth cell completes a row, which is a win not a draw.
    play(0, 1, 0, 1); play(0, 0, 0, 0); play(0, 2, 1, 1);
    play(0, 2, 0, 0); play(0, 0, 2, 1); play(0, 0, 1, 0);
    play(0, 1, 2, 1); play(0, 1, 1, 0); play(0, 2, 2, 3);
    check("g3_games", obs(0, 5), 3);
    check("g3_p1", obs(0, 2), 482);
    check("g3_p2", obs(0, 3), 29);

    // u_c, 5x5 K=4: threes do not win; P2 fills the gap of an anti-diagonal.
    play(2, 0, 0, 1); play(2, 4, 0, 0);
    play(2, 1, 0, 1); play(2, 2, 2, 0);
    play(2, 2, 0, 1); play(2, 1, 3, 0);
    play(2, 0, 2, 1); play(2, 0, 4, 0);
    play(2, 4, 4, 1); play(2, 3, 1, 4);
    check("c_games", obs(2, 5), 1);
    check("c_p1", obs(2, 2), 32'd16778247);
    check("c_p2", obs(2, 3), 32'd1118480);

    // u_d: alternating starter, then reset during a scan.
    play(3, 0, 0, 1); play(3, 0, 1, 0); play(3, 1, 0, 1);
    play(3, 1, 1, 0); play(3, 2, 0, 3);
    check("d_games", obs(3, 5), 1);
    new_game(3, 1);
    press(3, 0);
    check("d_scan_busy", obs(3, 6), 1);
    check("d_scan_p2", obs(3, 3), 32'h010);
    rst = 1'b1;
    #1;
    for (int f = 0; f < 7; f++)
      check($sformatf("d_midrst_f%0d", f), obs(3, f), 0);
    #2;
    rst = 1'b0;
    @(negedge clk);
    check("d_post_rst_state", obs(3, 4), 0);
    check("d_post_rst_busy", obs(3, 6), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
